// File: rtl/esc_sequencer.sv
// esc_sequencer
//   Start-up / run / stop / fault sequencer for a sensored ESC.
//   Aligns the rotor at a fixed period, ramps the period reference one
//   count at a time toward the requested period, holds it in RUN, brakes on
//   a stop request and latches faults (external or encoder stall).
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start         spin-up request
//   stop          controlled stop request
//   fault_in      external fault (level)
//   clear_fault   leave FAULT (ignored while fault_in is high)
//   target_period requested period reference (smaller = faster)
//   ramp_div      clocks per ramp step minus one
//   speed_period  measured encoder period
//   stall_limit   slow threshold for stall detection (0 = off)
//   drive_en      allow PWM drive
//   brake         brake request
//   period_cmd    period reference to the ESC
//   state         current state code
//   fault         in FAULT
//   fault_code    01 external, 10 stall, 00 none
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | drive off, period at START_PERIOD, waiting for start
// ALIGN | drive on at START_PERIOD for ALIGN_CYCLES clocks
// RAMP  | step period_cmd toward target_period every ramp_div+1 clocks
// RUN   | hold period_cmd, re-ramp when target changes
// BRAKE | drive off, brake on for BRAKE_CYCLES clocks, then IDLE
// FAULT | drive off, brake on, wait for clear_fault with fault_in low
module esc_sequencer #(
  parameter int                        DATA_WIDTH   = 16,
  parameter logic [DATA_WIDTH/2-1:0]   START_PERIOD = 8'd200,
  parameter int                        ALIGN_CYCLES = 1000,
  parameter int                        BRAKE_CYCLES = 500,
  parameter int                        STALL_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      fault_in,
  input  logic                      clear_fault,
  input  logic [DATA_WIDTH/2-1:0]   target_period,
  input  logic [DATA_WIDTH-1:0]     ramp_div,
  input  logic [DATA_WIDTH-1:0]     speed_period,
  input  logic [DATA_WIDTH-1:0]     stall_limit,
  output logic                      drive_en,
  output logic                      brake,
  output logic [DATA_WIDTH/2-1:0]   period_cmd,
  output logic [2:0]                state,
  output logic                      fault,
  output logic [1:0]                fault_code
);

  localparam int PW   = DATA_WIDTH / 2;
  localparam int TMAX = (ALIGN_CYCLES > BRAKE_CYCLES) ? ALIGN_CYCLES : BRAKE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(STALL_CYCLES + 1);

  // Down-counter loads: the timer expires on the clock it reads zero, so
  // loading N-1 gives exactly N clocks in the state.
  localparam logic [TW-1:0] ALIGN_LOAD = TW'(ALIGN_CYCLES - 1);
  localparam logic [TW-1:0] BRAKE_LOAD = TW'(BRAKE_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_EXT   = 2'b01;
  localparam logic [1:0] CODE_STALL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_BRAKE = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         period_q, period_d;
  logic [1:0]            code_q, code_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] presc_q, presc_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic                  stall_cond;

  assign stall_cond = (stall_limit != '0) && (speed_period >= stall_limit);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    code_d   = code_q;
    timer_d  = timer_q;
    presc_d  = '0;
    stall_d  = '0;

    case (state_q)
      S_IDLE: begin
        period_d = START_PERIOD;
        if (fault_in) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (start) begin
          state_d = S_ALIGN;
          timer_d = ALIGN_LOAD;
        end
      end

      S_ALIGN: begin
        period_d = START_PERIOD;
        if (fault_in) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (stop) begin
          state_d = S_BRAKE;
          timer_d = BRAKE_LOAD;
        end else if (timer_q == '0) begin
          state_d = S_RAMP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_RAMP: begin
        if (fault_in) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (stop) begin
          state_d = S_BRAKE;
          timer_d = BRAKE_LOAD;
        end else if (stall_cond && stall_q == STALL_LAST) begin
          state_d = S_FAULT;
          code_d  = CODE_STALL;
        end else begin
          stall_d = stall_cond ? stall_q + 1'b1 : '0;
          if (period_q == target_period) begin
            state_d = S_RUN;
          end else if (presc_q >= ramp_div) begin
            // >= rather than == so a live drop of ramp_div below the
            // current count steps immediately instead of wrapping.
            period_d = (period_q > target_period) ? period_q - 1'b1
                                                  : period_q + 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        if (fault_in) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (stop) begin
          state_d = S_BRAKE;
          timer_d = BRAKE_LOAD;
        end else if (stall_cond && stall_q == STALL_LAST) begin
          state_d = S_FAULT;
          code_d  = CODE_STALL;
        end else begin
          stall_d = stall_cond ? stall_q + 1'b1 : '0;
          if (target_period != period_q) state_d = S_RAMP;
        end
      end

      S_BRAKE: begin
        if (fault_in) begin
          state_d = S_FAULT;
          code_d  = CODE_EXT;
        end else if (timer_q == '0) begin
          state_d  = S_IDLE;
          period_d = START_PERIOD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_FAULT: begin
        if (clear_fault && !fault_in) begin
          state_d  = S_IDLE;
          code_d   = CODE_NONE;
          period_d = START_PERIOD;
        end
      end

      default: begin
        state_d  = S_IDLE;
        code_d   = CODE_NONE;
        period_d = START_PERIOD;
        timer_d  = '0;
      end
    endcase
  end

  // Output flags are registered from the next state so they change on the
  // same edge as the state code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= START_PERIOD;
      code_q   <= CODE_NONE;
      timer_q  <= '0;
      presc_q  <= '0;
      stall_q  <= '0;
      drive_en <= 1'b0;
      brake    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      stall_q  <= stall_d;
      drive_en <= (state_d == S_ALIGN) || (state_d == S_RAMP) || (state_d == S_RUN);
      brake    <= (state_d == S_BRAKE) || (state_d == S_FAULT);
      fault    <= (state_d == S_FAULT);
    end
  end

  assign state      = state_q;
  assign period_cmd = period_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_esc_sequencer.sv
// tb_esc_sequencer
//   Directed bench for esc_sequencer with short timers
//   (ALIGN 4, BRAKE 3, STALL 5, START_PERIOD 10).
module tb_esc_sequencer;

  localparam int DW = 16;
  localparam int PW = DW / 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] RAMP  = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] BRAKE = 3'd4;
  localparam logic [2:0] FAULT = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, fault_in, clear_fault;
  logic [PW-1:0] target_period;
  logic [DW-1:0] ramp_div, speed_period, stall_limit;
  logic          drive_en, brake, fault;
  logic [PW-1:0] period_cmd;
  logic [2:0]    state;
  logic [1:0]    fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  esc_sequencer #(
    .DATA_WIDTH   (DW),
    .START_PERIOD (8'd10),
    .ALIGN_CYCLES (4),
    .BRAKE_CYCLES (3),
    .STALL_CYCLES (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .fault_in      (fault_in),
    .clear_fault   (clear_fault),
    .target_period (target_period),
    .ramp_div      (ramp_div),
    .speed_period  (speed_period),
    .stall_limit   (stall_limit),
    .drive_en      (drive_en),
    .brake         (brake),
    .period_cmd    (period_cmd),
    .state         (state),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  typedef struct {
    logic          rst;
    logic          start;
    logic          stop;
    logic [2:0]    st;
    logic          de;
    logic          br;
    logic [PW-1:0] per;
  } vec_t;

  vec_t vecs[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic de,
                           input logic br, input logic [PW-1:0] per,
                           input logic flt, input logic [1:0] code);
    check({tag, ".state"},      int'(state),      int'(st));
    check({tag, ".drive_en"},   int'(drive_en),   int'(de));
    check({tag, ".brake"},      int'(brake),      int'(br));
    check({tag, ".period_cmd"}, int'(period_cmd), int'(per));
    check({tag, ".fault"},      int'(fault),      int'(flt));
    check({tag, ".fault_code"}, int'(fault_code), int'(code));
  endtask

  // From IDLE with target_period equal to START_PERIOD: ALIGN then RAMP then RUN.
  task automatic spin_to_run(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check({tag, ".in_ramp"}, int'(state), int'(RAMP));
    step();
    check({tag, ".in_run"}, int'(state), int'(RUN));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; fault_in = 1'b0; clear_fault = 1'b0;
    target_period = 8'd7; ramp_div = 16'd1; speed_period = '0; stall_limit = '0;

    // Nominal spin-up, run, stop, brake, back to idle (one vector per clock).
    vecs[0]  = '{1'b1, 1'b0, 1'b0, IDLE,  1'b0, 1'b0, 8'd10};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, IDLE,  1'b0, 1'b0, 8'd10};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, ALIGN, 1'b1, 1'b0, 8'd10};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, ALIGN, 1'b1, 1'b0, 8'd10};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, ALIGN, 1'b1, 1'b0, 8'd10};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, ALIGN, 1'b1, 1'b0, 8'd10};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd10};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd10};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd9};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd9};
    vecs[10] = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd8};
    vecs[11] = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd8};
    vecs[12] = '{1'b0, 1'b0, 1'b0, RAMP,  1'b1, 1'b0, 8'd7};
    vecs[13] = '{1'b0, 1'b0, 1'b0, RUN,   1'b1, 1'b0, 8'd7};
    vecs[14] = '{1'b0, 1'b0, 1'b0, RUN,   1'b1, 1'b0, 8'd7};
    vecs[15] = '{1'b0, 1'b0, 1'b1, BRAKE, 1'b0, 1'b1, 8'd7};
    vecs[16] = '{1'b0, 1'b1, 1'b0, BRAKE, 1'b0, 1'b1, 8'd7};
    vecs[17] = '{1'b0, 1'b0, 1'b0, BRAKE, 1'b0, 1'b1, 8'd7};
    vecs[18] = '{1'b0, 1'b0, 1'b0, IDLE,  1'b0, 1'b0, 8'd10};
    vecs[19] = '{1'b0, 1'b0, 1'b1, IDLE,  1'b0, 1'b0, 8'd10};

    for (int i = 0; i < 20; i++) begin
      reset = vecs[i].rst;
      start = vecs[i].start;
      stop  = vecs[i].stop;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].de, vecs[i].br,
                vecs[i].per, 1'b0, 2'b00);
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;

    // fault_in together with stop in RAMP; clear only once fault_in drops.
    target_period = 8'd5; ramp_div = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check_all("flt.ramp", RAMP, 1'b1, 1'b0, 8'd10, 1'b0, 2'b00);
    fault_in = 1'b1; stop = 1'b1;
    step();
    check_all("flt.enter", FAULT, 1'b0, 1'b1, 8'd10, 1'b1, 2'b01);
    stop = 1'b0; clear_fault = 1'b1;
    step();
    check_all("flt.hold", FAULT, 1'b0, 1'b1, 8'd10, 1'b1, 2'b01);
    fault_in = 1'b0;
    step();
    check_all("flt.clear", IDLE, 1'b0, 1'b0, 8'd10, 1'b0, 2'b00);
    clear_fault = 1'b0;

    // Stall: exactly 5 slow clocks in RUN.
    target_period = 8'd10; ramp_div = 16'd0; stall_limit = 16'd100; speed_period = 16'd0;
    spin_to_run("stall1");
    speed_period = 16'd200;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall1.wait%0d", i), int'(state), int'(RUN));
    end
    step();
    check_all("stall1.trip", FAULT, 1'b0, 1'b1, 8'd10, 1'b1, 2'b10);
    speed_period = 16'd0; clear_fault = 1'b1;
    step();
    check_all("stall1.clear", IDLE, 1'b0, 1'b0, 8'd10, 1'b0, 2'b00);
    clear_fault = 1'b0;

    // A single fast sample restarts the count.
    spin_to_run("stall2");
    speed_period = 16'd200;
    repeat (3) step();
    speed_period = 16'd50;
    step();
    check("stall2.dip", int'(state), int'(RUN));
    speed_period = 16'd200;
    repeat (4) step();
    check("stall2.wait", int'(state), int'(RUN));
    step();
    check("stall2.trip_state", int'(state), int'(FAULT));
    check("stall2.trip_code", int'(fault_code), 2);
    speed_period = 16'd0; clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("stall2.clear", int'(state), int'(IDLE));

    // stall_limit = 0 disables detection.
    stall_limit = 16'd0;
    spin_to_run("stall3");
    speed_period = 16'd200;
    repeat (10) step();
    check("stall3.no_trip", int'(state), int'(RUN));
    check("stall3.no_fault", int'(fault), 0);
    speed_period = 16'd0;

    // Downward ramp with ramp_div = 0, then target change 7 -> 9 in RUN.
    target_period = 8'd7;
    step();
    check_all("tgt.down0", RAMP, 1'b1, 1'b0, 8'd10, 1'b0, 2'b00);
    step(); check("tgt.down1", int'(period_cmd), 9);
    step(); check("tgt.down2", int'(period_cmd), 8);
    step(); check("tgt.down3", int'(period_cmd), 7);
    step();
    check_all("tgt.run7", RUN, 1'b1, 1'b0, 8'd7, 1'b0, 2'b00);
    target_period = 8'd9;
    step();
    check_all("tgt.ramp7", RAMP, 1'b1, 1'b0, 8'd7, 1'b0, 2'b00);
    step(); check("tgt.up8", int'(period_cmd), 8);
    step(); check("tgt.up9", int'(period_cmd), 9);
    step();
    check_all("tgt.run9", RUN, 1'b1, 1'b0, 8'd9, 1'b0, 2'b00);

    // Reset mid-RAMP with other inputs active, then a normal restart.
    target_period = 8'd5; ramp_div = 16'd2;
    step();
    check("rst.ramp", int'(state), int'(RAMP));
    step();
    reset = 1'b1; start = 1'b1; fault_in = 1'b1; stop = 1'b1;
    step();
    check_all("rst.applied", IDLE, 1'b0, 1'b0, 8'd10, 1'b0, 2'b00);
    reset = 1'b0; fault_in = 1'b0; stop = 1'b0; start = 1'b1;
    step();
    check_all("rst.align", ALIGN, 1'b1, 1'b0, 8'd10, 1'b0, 2'b00);
    start = 1'b0;
    repeat (3) step();
    check("rst.align_end", int'(state), int'(ALIGN));
    step();
    check_all("rst.ramp_again", RAMP, 1'b1, 1'b0, 8'd10, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/esc_sequencer.md
ESC_SEQUENCER -- requirements
Module: esc_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of speed_period, stall_limit and ramp_div.
REQ-002 SHALL have parameter START_PERIOD, default 8'd200, period_cmd value used in IDLE and ALIGN.
REQ-003 SHALL have parameter ALIGN_CYCLES, default 1000, ALIGN state duration in clocks (minimum 1).
REQ-004 SHALL have parameter BRAKE_CYCLES, default 500, BRAKE state duration in clocks (minimum 1).
REQ-005 SHALL have parameter STALL_CYCLES, default 4096, consecutive slow cycles before stall fault (minimum 1).
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-007 SHALL have these ports: start in 1, spin-up request; stop in 1, controlled stop request; fault_in in 1, external fault (overcurrent/driver), level.
REQ-008 SHALL have these ports: clear_fault in 1, leave FAULT; target_period in DATA_WIDTH/2, requested speed period (smaller = faster); ramp_div in DATA_WIDTH, clocks per ramp step minus one.
REQ-009 SHALL have these ports: speed_period in DATA_WIDTH, measured encoder period; stall_limit in DATA_WIDTH, slow threshold (0 = stall detection off).
REQ-010 SHALL have these ports: drive_en out 1, allow PWM drive; brake out 1, brake request; period_cmd out DATA_WIDTH/2, period reference to ESC.
REQ-011 SHALL have these ports: state out 3, current state code; fault out 1, in FAULT; fault_code out 2, 01 external, 10 stall, 00 none.

Function
REQ-012 SHALL implement states IDLE=0, ALIGN=1, RAMP=2, RUN=3, BRAKE=4, FAULT=5; codes 6-7 unreachable, recover to IDLE next cycle.
REQ-013 SHALL register all outputs; a transition decided at edge N shows on outputs after edge N.
REQ-014 SHALL apply event priority reset > fault_in > stop > start > timers/ramp.
REQ-015 SHALL in IDLE drive drive_en=0, brake=0, period_cmd=START_PERIOD; start=1 -> ALIGN; stop ignored.
REQ-016 SHALL in ALIGN drive drive_en=1, period_cmd=START_PERIOD for exactly ALIGN_CYCLES clocks, then -> RAMP with prescaler cleared.
REQ-017 SHALL in RAMP count prescaler 0..ramp_div (ramp_div sampled live); at ramp_div, step period_cmd by 1 toward target_period and clear prescaler; ramp_div=0 steps every clock.
REQ-018 SHALL go RAMP -> RUN on the clock after period_cmd equals target_period; no step past target; no overflow or underflow of period_cmd.
REQ-019 SHALL in RUN hold drive_en=1 and period_cmd; target_period != period_cmd -> RAMP with prescaler cleared.
REQ-020 SHALL on stop=1 in ALIGN, RAMP or RUN -> BRAKE; in BRAKE drive drive_en=0, brake=1, period_cmd held, for exactly BRAKE_CYCLES clocks, then -> IDLE; start and stop ignored in BRAKE.
REQ-021 SHALL on fault_in=1 in any state except FAULT -> FAULT with fault_code=01.
REQ-022 SHALL keep a stall counter, active in RAMP/RUN only when stall_limit != 0; it increments while speed_period >= stall_limit, clears otherwise and in all other states.
REQ-023 SHALL go -> FAULT with fault_code=10 when the stall condition has held STALL_CYCLES consecutive clocks.
REQ-024 SHALL in FAULT drive drive_en=0, brake=1, fault=1; fault_code held; clear_fault=1 with fault_in=0 -> IDLE with fault_code=00; clear_fault while fault_in=1 ignored.
REQ-025 SHALL keep brake=0 in IDLE, ALIGN, RAMP and RUN, and never assert drive_en and brake together.

Reset
REQ-026 SHALL on reset=1 at a clock edge, in any state including mid-ramp or FAULT, set state=IDLE, drive_en=0, brake=0, fault=0, fault_code=00, period_cmd=START_PERIOD, all counters 0.
REQ-027 SHALL ignore all other inputs on a clock edge with reset=1.

Verification (ALIGN_CYCLES=4, BRAKE_CYCLES=3, STALL_CYCLES=5, START_PERIOD=10)
REQ-028 SHALL cover nominal spin-up: start pulse, target_period=7, ramp_div=1 -> drive_en rises one clock later; ALIGN 4 clocks; period_cmd 10,9,8,7 every 2 clocks; RUN after reaching 7.
REQ-029 SHALL cover stop in RUN -> BRAKE with drive_en=0, brake=1 for 3 clocks, then IDLE with brake=0.
REQ-030 SHALL cover fault_in and stop asserted together in RAMP -> FAULT, fault_code=01; clear_fault with fault_in=1 stays FAULT; clear_fault after fault_in=0 -> IDLE.
REQ-031 SHALL cover stall_limit=100 with speed_period=200 in RUN -> FAULT, fault_code=10, exactly 5 clocks later; a single dip to 50 restarts the count; stall_limit=0 never faults.
REQ-032 SHALL cover a target change in RUN from 7 to 9 with ramp_div=0 -> RAMP, period_cmd 8 then 9, then RUN.
REQ-033 SHALL cover reset asserted mid-RAMP -> next clock all outputs at REQ-026 values, and start one clock later begins ALIGN normally.
